// File: rtl/aes_subbytes_pipe.sv
// aes_subbytes_pipe: multi-lane AES SubBytes / InvSubBytes unit.
// Two register stages with a valid/ready handshake. Each lane has its own
// forward and inverse 256-entry lookup table between the stages. The mode bit
// travels with each word, so forward and inverse words may be mixed freely.
module aes_subbytes_pipe #(
    parameter int NUM_BYTES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_inv,
    input  logic [8*NUM_BYTES-1:0] in_data,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic                   out_inv,
    output logic [8*NUM_BYTES-1:0] out_data
);

    localparam int W = 8 * NUM_BYTES;

    // FIPS-197 forward S-box, indexed by the input byte.
    localparam logic [7:0] FWD_SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

    // FIPS-197 inverse S-box, indexed by the input byte.
    localparam logic [7:0] INV_SBOX [256] = '{
        8'h52, 8'h09, 8'h6a, 8'hd5, 8'h30, 8'h36, 8'ha5, 8'h38, 8'hbf, 8'h40, 8'ha3, 8'h9e, 8'h81, 8'hf3, 8'hd7, 8'hfb,
        8'h7c, 8'he3, 8'h39, 8'h82, 8'h9b, 8'h2f, 8'hff, 8'h87, 8'h34, 8'h8e, 8'h43, 8'h44, 8'hc4, 8'hde, 8'he9, 8'hcb,
        8'h54, 8'h7b, 8'h94, 8'h32, 8'ha6, 8'hc2, 8'h23, 8'h3d, 8'hee, 8'h4c, 8'h95, 8'h0b, 8'h42, 8'hfa, 8'hc3, 8'h4e,
        8'h08, 8'h2e, 8'ha1, 8'h66, 8'h28, 8'hd9, 8'h24, 8'hb2, 8'h76, 8'h5b, 8'ha2, 8'h49, 8'h6d, 8'h8b, 8'hd1, 8'h25,
        8'h72, 8'hf8, 8'hf6, 8'h64, 8'h86, 8'h68, 8'h98, 8'h16, 8'hd4, 8'ha4, 8'h5c, 8'hcc, 8'h5d, 8'h65, 8'hb6, 8'h92,
        8'h6c, 8'h70, 8'h48, 8'h50, 8'hfd, 8'hed, 8'hb9, 8'hda, 8'h5e, 8'h15, 8'h46, 8'h57, 8'ha7, 8'h8d, 8'h9d, 8'h84,
        8'h90, 8'hd8, 8'hab, 8'h00, 8'h8c, 8'hbc, 8'hd3, 8'h0a, 8'hf7, 8'he4, 8'h58, 8'h05, 8'hb8, 8'hb3, 8'h45, 8'h06,
        8'hd0, 8'h2c, 8'h1e, 8'h8f, 8'hca, 8'h3f, 8'h0f, 8'h02, 8'hc1, 8'haf, 8'hbd, 8'h03, 8'h01, 8'h13, 8'h8a, 8'h6b,
        8'h3a, 8'h91, 8'h11, 8'h41, 8'h4f, 8'h67, 8'hdc, 8'hea, 8'h97, 8'hf2, 8'hcf, 8'hce, 8'hf0, 8'hb4, 8'he6, 8'h73,
        8'h96, 8'hac, 8'h74, 8'h22, 8'he7, 8'had, 8'h35, 8'h85, 8'he2, 8'hf9, 8'h37, 8'he8, 8'h1c, 8'h75, 8'hdf, 8'h6e,
        8'h47, 8'hf1, 8'h1a, 8'h71, 8'h1d, 8'h29, 8'hc5, 8'h89, 8'h6f, 8'hb7, 8'h62, 8'h0e, 8'haa, 8'h18, 8'hbe, 8'h1b,
        8'hfc, 8'h56, 8'h3e, 8'h4b, 8'hc6, 8'hd2, 8'h79, 8'h20, 8'h9a, 8'hdb, 8'hc0, 8'hfe, 8'h78, 8'hcd, 8'h5a, 8'hf4,
        8'h1f, 8'hdd, 8'ha8, 8'h33, 8'h88, 8'h07, 8'hc7, 8'h31, 8'hb1, 8'h12, 8'h10, 8'h59, 8'h27, 8'h80, 8'hec, 8'h5f,
        8'h60, 8'h51, 8'h7f, 8'ha9, 8'h19, 8'hb5, 8'h4a, 8'h0d, 8'h2d, 8'he5, 8'h7a, 8'h9f, 8'h93, 8'hc9, 8'h9c, 8'hef,
        8'ha0, 8'he0, 8'h3b, 8'h4d, 8'hae, 8'h2a, 8'hf5, 8'hb0, 8'hc8, 8'heb, 8'hbb, 8'h3c, 8'h83, 8'h53, 8'h99, 8'h61,
        8'h17, 8'h2b, 8'h04, 8'h7e, 8'hba, 8'h77, 8'hd6, 8'h26, 8'he1, 8'h69, 8'h14, 8'h63, 8'h55, 8'h21, 8'h0c, 8'h7d
    };

    logic         s1_valid_q, s1_valid_d;
    logic         s1_inv_q, s1_inv_d;
    logic [W-1:0] s1_data_q, s1_data_d;
    logic         s2_valid_q, s2_valid_d;
    logic         s2_inv_q, s2_inv_d;
    logic [W-1:0] s2_data_q, s2_data_d;
    logic [W-1:0] sub_data;
    logic         s2_load;
    logic         s1_free;
    logic         accept;

    // Per-lane substitution; every 8-bit index is a valid table entry, so
    // there is no out-of-range case to handle.
    for (genvar gi = 0; gi < NUM_BYTES; gi++) begin : g_lane
        assign sub_data[8*gi +: 8] = s1_inv_q ? INV_SBOX[s1_data_q[8*gi +: 8]]
                                              : FWD_SBOX[s1_data_q[8*gi +: 8]];
    end

    // Handshake and next-state logic for both stages.
    always_comb begin
        s2_load    = s1_valid_q && (!s2_valid_q || out_ready);
        s1_free    = !s1_valid_q || s2_load;
        accept     = in_valid && s1_free;

        s1_valid_d = accept ? 1'b1 : (s2_load ? 1'b0 : s1_valid_q);
        s1_data_d  = accept ? in_data : s1_data_q;
        s1_inv_d   = accept ? in_inv : s1_inv_q;

        s2_valid_d = s2_load ? 1'b1 : (out_ready ? 1'b0 : s2_valid_q);
        s2_data_d  = s2_load ? sub_data : s2_data_q;
        s2_inv_d   = s2_load ? s1_inv_q : s2_inv_q;
    end

    // Pipeline registers; reset drops any in-flight words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_inv_q   <= 1'b0;
            s1_data_q  <= '0;
            s2_valid_q <= 1'b0;
            s2_inv_q   <= 1'b0;
            s2_data_q  <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_inv_q   <= s1_inv_d;
            s1_data_q  <= s1_data_d;
            s2_valid_q <= s2_valid_d;
            s2_inv_q   <= s2_inv_d;
            s2_data_q  <= s2_data_d;
        end
    end

    assign in_ready  = s1_free;
    assign out_valid = s2_valid_q;
    assign out_inv   = s2_inv_q;
    assign out_data  = s2_data_q;

endmodule

// File: tb/tb_aes_subbytes_pipe.sv
// Testbench for aes_subbytes_pipe: table vectors, exhaustive round trip,
// streaming, backpressure, asynchronous reset and a 4-lane SubWord build.
module tb_aes_subbytes_pipe;

    logic         clk = 1'b0;
    logic         rst;
    logic         in_valid, in_ready, in_inv, out_valid, out_ready, out_inv;
    logic [127:0] in_data, out_data;
    logic         v4, r4, inv4, ov4, or4, oinv4;
    logic [31:0]  d4, od4;

    int errors = 0;
    int checks = 0;
    int n_out  = 0;

    logic [7:0]   fwd_m [256];
    logic [7:0]   inv_m [256];
    logic [128:0] sb [$];
    logic         prev_stall = 1'b0;
    logic [127:0] prev_data  = '0;

    typedef struct {
        logic         inv;
        logic [127:0] din;
        logic [127:0] dout;
    } vec_t;
    vec_t vecs [4];

    aes_subbytes_pipe #(.NUM_BYTES(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_inv(in_inv), .in_data(in_data), .out_valid(out_valid),
        .out_ready(out_ready), .out_inv(out_inv), .out_data(out_data)
    );

    aes_subbytes_pipe #(.NUM_BYTES(4)) dut4 (
        .clk(clk), .rst(rst), .in_valid(v4), .in_ready(r4),
        .in_inv(inv4), .in_data(d4), .out_valid(ov4),
        .out_ready(or4), .out_inv(oinv4), .out_data(od4)
    );

    always #5 clk = ~clk;

    // GF(2^8) arithmetic with the AES polynomial x^8+x^4+x^3+x+1
    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        logic [7:0] y = b;
        for (int k = 0; k < 8; k++) begin
            if (y[0]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
            y = y >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] b, input int n);
        return (b << n) | (b >> (8 - n));
    endfunction

    // S-box from its definition: multiplicative inverse then affine map
    function automatic logic [7:0] sbox_def(input logic [7:0] x);
        logic [7:0] r = 8'h01;
        if (x == 8'h00) r = 8'h00;
        else for (int k = 0; k < 254; k++) r = gmul(r, x);
        return r ^ rotl(r, 1) ^ rotl(r, 2) ^ rotl(r, 3) ^ rotl(r, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] model_word(input logic inv, input logic [127:0] d);
        logic [127:0] r;
        for (int k = 0; k < 16; k++)
            r[8*k +: 8] = inv ? inv_m[d[8*k +: 8]] : fwd_m[d[8*k +: 8]];
        return r;
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Scoreboard: samples handshakes mid-cycle and checks every presented word
    always @(negedge clk) begin
        #2;
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (out_valid) begin
                if (sb.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL sb_unexpected: got %h expected no output", out_data);
                end else begin
                    chk("sb_data", out_data, sb[0][127:0]);
                    chk("sb_inv", {127'b0, out_inv}, {127'b0, sb[0][128]});
                    if (out_ready) begin
                        void'(sb.pop_front());
                        n_out++;
                    end
                end
            end
            if (prev_stall && out_valid) chk("stall_stable", out_data, prev_data);
            if (in_valid && in_ready) sb.push_back({in_inv, model_word(in_inv, in_data)});
            prev_stall = out_valid && !out_ready;
            prev_data  = out_data;
        end
    end

    // Send one word, then wait (bounded) for it at the output
    task automatic send_get(input logic inv, input logic [127:0] d,
                            output logic [127:0] q, output logic qinv, output int lat);
        int guard = 0;
        @(negedge clk);
        in_valid = 1'b1; in_inv = inv; in_data = d;
        #2;
        while (!in_ready && guard < 20) begin @(negedge clk); #2; guard++; end
        if (!in_ready) begin checks++; errors++; $display("FAIL accept_timeout: got in_ready=0 expected 1"); end
        @(negedge clk);
        in_valid = 1'b0; lat = 1;
        #2;
        guard = 0;
        while (!out_valid && guard < 20) begin @(negedge clk); #2; lat++; guard++; end
        if (!out_valid) begin checks++; errors++; $display("FAIL output_timeout: got out_valid=0 expected 1"); end
        q = out_data; qinv = out_inv;
    endtask

    initial begin
        logic [127:0] q, q2, d, held, pend;
        logic         qi, pend_inv;
        int           lat, stall, seen, gap, acc, n0;

        for (int k = 0; k < 256; k++) fwd_m[k] = sbox_def(k[7:0]);
        for (int k = 0; k < 256; k++) inv_m[fwd_m[k]] = k[7:0];

        vecs[0] = '{1'b0, {4{32'h19FF5300}}, {4{32'hD416ED63}}};
        vecs[1] = '{1'b1, {4{32'hD416ED63}}, {4{32'h19FF5300}}};
        vecs[2] = '{1'b0, {4{32'h10010053}}, {4{32'hCA7C63ED}}};
        vecs[3] = '{1'b1, {4{32'hCA7C63ED}}, {4{32'h10010053}}};

        rst = 1'b1; in_valid = 1'b0; in_inv = 1'b0; in_data = '0; out_ready = 1'b1;
        v4 = 1'b0; inv4 = 1'b0; d4 = '0; or4 = 1'b1;
        #12;
        chk("rst_out_valid", {127'b0, out_valid}, 128'd0);
        chk("rst_out_data", out_data, 128'd0);
        chk("rst_out_inv", {127'b0, out_inv}, 128'd0);
        chk("rst_in_ready", {127'b0, in_ready}, 128'd1);
        @(negedge clk);
        rst = 1'b0;

        // SubWord example on the 4-lane build
        @(negedge clk);
        v4 = 1'b1; d4 = 32'hCF4F3C09; inv4 = 1'b0;
        @(negedge clk);
        v4 = 1'b0;
        #2 chk("sw_valid_early", {127'b0, ov4}, 128'd0);
        @(negedge clk);
        #2 chk("sw_valid", {127'b0, ov4}, 128'd1);
        chk("sw_data", {96'b0, od4}, {96'b0, 32'h8A84EB01});

        // Table-driven vectors with latency check
        for (int i = 0; i < 4; i++) begin
            send_get(vecs[i].inv, vecs[i].din, q, qi, lat);
            $display("vec %0d inv=%0d in=%h out=%h lat=%0d", i, vecs[i].inv, vecs[i].din, q, lat);
            chk("vec_latency", lat, 2);
            chk("vec_data", q, vecs[i].dout);
            chk("vec_inv", {127'b0, qi}, {127'b0, vecs[i].inv});
        end

        // Exhaustive round trip through lane 0 (other lanes random)
        for (int x = 0; x < 256; x++) begin
            d = rand128();
            d[7:0] = x[7:0];
            send_get(1'b0, d, q, qi, lat);
            chk("sweep_latency", lat, 2);
            send_get(1'b1, q, q2, qi, lat);
            chk("sweep_roundtrip", q2, d);
        end
        $display("sweep done: 256 round trips");

        // Streaming 100 words, alternating mode
        stall = 0; seen = 0; gap = 0;
        out_ready = 1'b1;
        for (int i = 0; i < 102; i++) begin
            @(negedge clk);
            if (i < 100) begin
                in_valid = 1'b1; in_inv = i[0]; in_data = rand128();
            end else begin
                in_valid = 1'b0;
            end
            #2;
            if (i < 100 && !in_ready) stall++;
            if (out_valid) seen++;
            else if (seen > 0 && seen < 100) gap++;
        end
        $display("stream: outputs=%0d stalls=%0d gaps=%0d", seen, stall, gap);
        chk("stream_stalls", stall, 0);
        chk("stream_count", seen, 100);
        chk("stream_gaps", gap, 0);

        // Backpressure: out_ready low for 5 cycles with input offered
        acc = 0; held = '0;
        pend = rand128(); pend_inv = 1'($urandom_range(0, 1));
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            out_ready = 1'b0; in_valid = 1'b1; in_inv = pend_inv; in_data = pend;
            #2;
            if (i == 2) held = out_data;
            if (in_ready) begin
                acc++;
                pend = rand128(); pend_inv = 1'($urandom_range(0, 1));
            end
        end
        $display("backpressure: accepted=%0d in_ready=%0d", acc, in_ready);
        chk("bp_accepted", acc, 2);
        chk("bp_in_ready", {127'b0, in_ready}, 128'd0);
        chk("bp_out_valid", {127'b0, out_valid}, 128'd1);
        chk("bp_held", out_data, held);
        n0 = n_out;
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        repeat (4) @(negedge clk);
        #3;
        chk("bp_drained", n_out - n0, 2);
        chk("bp_sb_empty", sb.size(), 0);

        // Asynchronous reset with both stages full
        @(negedge clk);
        out_ready = 1'b0; in_valid = 1'b1; in_inv = 1'b0; in_data = rand128();
        @(negedge clk);
        in_inv = 1'b1; in_data = rand128();
        @(negedge clk);
        in_valid = 1'b0;
        #2;
        chk("full_out_valid", {127'b0, out_valid}, 128'd1);
        chk("full_in_ready", {127'b0, in_ready}, 128'd0);
        #1 rst = 1'b1;
        #1;
        chk("arst_out_valid", {127'b0, out_valid}, 128'd0);
        chk("arst_in_ready", {127'b0, in_ready}, 128'd1);
        chk("arst_out_data", out_data, 128'd0);
        chk("arst_out_inv", {127'b0, out_inv}, 128'd0);
        rst = 1'b0;
        sb.delete();
        out_ready = 1'b1;
        d = rand128();
        send_get(1'b0, d, q, qi, lat);
        $display("post-reset word in=%h out=%h lat=%0d", d, q, lat);
        chk("post_rst_latency", lat, 2);
        chk("post_rst_data", q, model_word(1'b0, d));
        repeat (3) @(negedge clk);
        #3;
        chk("final_sb_empty", sb.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
